// File: rtl/warmboot_req_if.sv
// Reboot request handshake between a bus agent and warmboot_req.
// The agent is the master (valid/sel) and warmboot_req is the slave (ready).
interface warmboot_req_if;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;

    modport master (output req_valid, output req_sel, input req_ready);
    modport slave  (input req_valid, input req_sel, output req_ready);
endinterface

// File: rtl/warmboot_req.sv
// Application-side warm-boot requester: detaches USB, waits, then drives and holds
// the SB_WARMBOOT pins. A bus request or a long button press can trigger it.
module warmboot_req #(
    parameter int unsigned DELAY_W = 16,
    parameter int unsigned LP_W    = 24,
    parameter bit          LP_EN   = 1'b1,
    parameter logic [1:0]  DFU_SEL = 2'b01
) (
    input  logic           clk,
    input  logic           rst,
    warmboot_req_if.slave  req,
    input  logic           btn_v,
    output logic           usb_detach,
    output logic           busy,
    output logic           wb_boot,
    output logic [1:0]     wb_sel
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DETACH = 2'b01,
        ST_BOOT   = 2'b10
    } state_t;

    state_t              state_q;
    logic [DELAY_W-1:0]  delay_q;
    logic [LP_W-1:0]     press_q;
    logic                btn_armed_q;
    logic                usb_detach_q;
    logic                busy_q;
    logic                wb_boot_q;
    logic [1:0]          wb_sel_q;
    logic                lp_hit;

    // The press counter only runs in IDLE, so a hit can only occur there.
    assign lp_hit = LP_EN && btn_armed_q && !btn_v && (press_q == '1) &&
                    (state_q == ST_IDLE);

    assign req.req_ready = (state_q == ST_IDLE);
    assign usb_detach    = usb_detach_q;
    assign busy          = busy_q;
    assign wb_boot       = wb_boot_q;
    assign wb_sel        = wb_sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            delay_q      <= '0;
            press_q      <= '0;
            btn_armed_q  <= 1'b0;
            usb_detach_q <= 1'b0;
            busy_q       <= 1'b0;
            wb_boot_q    <= 1'b0;
            wb_sel_q     <= 2'b00;
        end else begin
            // Arm only after a release, so a button held through power-up never fires.
            if (btn_v) begin
                btn_armed_q <= 1'b1;
            end

            if (btn_v || (state_q != ST_IDLE)) begin
                press_q <= '0;
            end else if (btn_armed_q) begin
                press_q <= press_q + 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    // Bus request takes priority over a coincident long press.
                    if (req.req_valid) begin
                        wb_sel_q     <= req.req_sel;
                        delay_q      <= '0;
                        usb_detach_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_DETACH;
                    end else if (lp_hit) begin
                        wb_sel_q     <= DFU_SEL;
                        delay_q      <= '0;
                        usb_detach_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_DETACH;
                    end
                end
                ST_DETACH: begin
                    delay_q <= delay_q + 1'b1;
                    if (delay_q == '1) begin
                        wb_boot_q <= 1'b1;
                        state_q   <= ST_BOOT;
                    end
                end
                ST_BOOT: begin
                    // Terminal: pins held until reset.
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_warmboot_req.sv
// Directed, table-driven bench for warmboot_req with DELAY_W=4, LP_W=5, plus a
// second instance with the long-press trigger disabled.
module tb_warmboot_req;

    localparam int unsigned DELAY_W = 4;
    localparam int unsigned LP_W    = 5;
    localparam int          DETACH_CYC = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_v, btn_v2;
    logic       usb_detach, busy, wb_boot;
    logic [1:0] wb_sel;
    logic       usb_detach2, busy2, wb_boot2;
    logic [1:0] wb_sel2;

    int checks = 0;
    int errors = 0;

    warmboot_req_if rq();
    warmboot_req_if rq2();

    warmboot_req #(.DELAY_W(DELAY_W), .LP_W(LP_W), .LP_EN(1'b1), .DFU_SEL(2'b01)) dut (
        .clk(clk), .rst(rst), .req(rq), .btn_v(btn_v),
        .usb_detach(usb_detach), .busy(busy), .wb_boot(wb_boot), .wb_sel(wb_sel)
    );

    warmboot_req #(.DELAY_W(DELAY_W), .LP_W(LP_W), .LP_EN(1'b0), .DFU_SEL(2'b01)) dut_nolp (
        .clk(clk), .rst(rst), .req(rq2), .btn_v(btn_v2),
        .usb_detach(usb_detach2), .busy(busy2), .wb_boot(wb_boot2), .wb_sel(wb_sel2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        int         exp_lat;
        logic [1:0] exp_sel;
    } req_vec_t;

    typedef struct {
        string      name;
        int         rel;
        int         p1;
        int         gap;
        int         p2;
        int         exp_hit;
        logic [1:0] exp_sel;
    } lp_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rq.req_valid = 1'b0;
        rq.req_sel = 2'b00;
        btn_v = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " usb_detach"}, 32'(usb_detach), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " wb_boot"}, 32'(wb_boot), 32'd0);
        chk({tag, " wb_sel"}, 32'(wb_sel), 32'd0);
        chk({tag, " req_ready"}, 32'(rq.req_ready), 32'd1);
    endtask

    // Steps until wb_boot rises; also reports whether req_ready was ever seen high.
    task automatic wait_boot(output int n, output bit ready_seen);
        n = 0;
        ready_seen = 1'b0;
        while (!wb_boot && n < 64) begin
            step();
            n++;
            if (rq.req_ready) ready_seen = 1'b1;
        end
    endtask

    task automatic run_lp(input lp_vec_t v);
        int pidx = 0;
        int hit = 0;
        do_reset();
        btn_v = 1'b1;
        repeat (v.rel) step();
        btn_v = 1'b0;
        for (int i = 0; i < v.p1; i++) begin
            step();
            pidx++;
            if (hit == 0 && usb_detach) hit = pidx;
        end
        btn_v = 1'b1;
        repeat (v.gap) step();
        btn_v = 1'b0;
        for (int i = 0; i < v.p2; i++) begin
            step();
            pidx++;
            if (hit == 0 && usb_detach) hit = pidx;
        end
        btn_v = 1'b1;
        chk({v.name, " hit_cycle"}, 32'(hit), 32'(v.exp_hit));
        if (v.exp_hit != 0) begin
            chk({v.name, " wb_sel"}, 32'(wb_sel), 32'(v.exp_sel));
        end else begin
            chk({v.name, " busy"}, 32'(busy), 32'd0);
            chk({v.name, " req_ready"}, 32'(rq.req_ready), 32'd1);
        end
    endtask

    initial begin
        req_vec_t rv[4];
        lp_vec_t  lv[4];
        int       n;
        bit       rdy;
        bit       any2;

        rv[0] = '{sel: 2'b10, exp_lat: DETACH_CYC, exp_sel: 2'b10};
        rv[1] = '{sel: 2'b00, exp_lat: DETACH_CYC, exp_sel: 2'b00};
        rv[2] = '{sel: 2'b11, exp_lat: DETACH_CYC, exp_sel: 2'b11};
        rv[3] = '{sel: 2'b01, exp_lat: DETACH_CYC, exp_sel: 2'b01};

        lv[0] = '{name: "lp32",        rel: 1, p1: 32,  gap: 0, p2: 0,  exp_hit: 32, exp_sel: 2'b01};
        lv[1] = '{name: "lp31_rel_31", rel: 1, p1: 31,  gap: 1, p2: 31, exp_hit: 0,  exp_sel: 2'b00};
        lv[2] = '{name: "held_boot",   rel: 0, p1: 100, gap: 0, p2: 0,  exp_hit: 0,  exp_sel: 2'b00};
        lv[3] = '{name: "lp31_only",   rel: 1, p1: 31,  gap: 0, p2: 0,  exp_hit: 0,  exp_sel: 2'b00};

        rq2.req_valid = 1'b0;
        rq2.req_sel = 2'b00;
        btn_v2 = 1'b1;

        // Bus request path.
        foreach (rv[i]) begin
            do_reset();
            chk_idle($sformatf("req%0d reset", i));
            btn_v = 1'b1;
            step();
            rq.req_valid = 1'b1;
            rq.req_sel = rv[i].sel;
            step();
            rq.req_valid = 1'b0;
            chk($sformatf("req%0d usb_detach", i), 32'(usb_detach), 32'd1);
            chk($sformatf("req%0d busy", i), 32'(busy), 32'd1);
            chk($sformatf("req%0d wb_boot_early", i), 32'(wb_boot), 32'd0);
            wait_boot(n, rdy);
            chk($sformatf("req%0d boot_latency", i), 32'(n), 32'(rv[i].exp_lat));
            chk($sformatf("req%0d ready_in_busy", i), 32'(rdy), 32'd0);
            chk($sformatf("req%0d wb_sel", i), 32'(wb_sel), 32'(rv[i].exp_sel));
            step();
            step();
            chk($sformatf("req%0d boot_hold", i), 32'(wb_boot), 32'd1);
        end

        // Long-press path.
        foreach (lv[i]) run_lp(lv[i]);

        // Request coincides with lp_hit; a later request in DETACH is ignored.
        do_reset();
        btn_v = 1'b1;
        step();
        btn_v = 1'b0;
        repeat (31) step();
        chk("tie pre_hit", 32'(usb_detach), 32'd0);
        rq.req_valid = 1'b1;
        rq.req_sel = 2'b11;
        step();
        chk("tie detach", 32'(usb_detach), 32'd1);
        chk("tie wb_sel", 32'(wb_sel), 32'd3);
        rq.req_sel = 2'b00;
        step();
        rq.req_valid = 1'b0;
        chk("detach_req_ignored", 32'(wb_sel), 32'd3);
        wait_boot(n, rdy);
        chk("tie boot_latency", 32'(n), 32'(DETACH_CYC - 1));
        chk("tie boot_sel", 32'(wb_sel), 32'd3);
        btn_v = 1'b1;

        // Async reset while in DETACH with timer at 7.
        do_reset();
        btn_v = 1'b1;
        step();
        rq.req_valid = 1'b1;
        rq.req_sel = 2'b10;
        step();
        rq.req_valid = 1'b0;
        repeat (7) step();
        chk("mid_detach still", 32'(usb_detach), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle("rst_detach");
        step();
        rst = 1'b0;
        step();
        chk_idle("rst_detach after");

        // Async reset while in BOOT.
        rq.req_valid = 1'b1;
        rq.req_sel = 2'b11;
        step();
        rq.req_valid = 1'b0;
        wait_boot(n, rdy);
        chk("pre_rst_boot wb_boot", 32'(wb_boot), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle("rst_boot");
        step();
        rst = 1'b0;
        step();
        chk_idle("rst_boot after");

        // Long press disabled: arm, then hold 200 cycles.
        btn_v2 = 1'b1;
        step();
        btn_v2 = 1'b0;
        any2 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (usb_detach2 || busy2 || wb_boot2) any2 = 1'b1;
        end
        chk("nolp any_activity", 32'(any2), 32'd0);
        chk("nolp req_ready", 32'(rq2.req_ready), 32'd1);
        btn_v2 = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
